// File: rtl/button_conditioner.sv
// Pushbutton front end: per-button synchronizer and debouncer, press/release
// edge pulses, and auto-repeating step pulses for the four direction buttons.
module button_conditioner #(
  parameter int DB_CYCLES  = 1000000,
  parameter int RPT_DELAY  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic       ClkPort,
  input  logic       ResetN,
  input  logic       BtnL,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnR,
  input  logic       BtnC,
  output logic [4:0] Level,
  output logic [4:0] Press,
  output logic [4:0] Release,
  output logic [3:0] Step
);

  localparam int DW      = $clog2(DB_CYCLES);
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX);

  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(RPT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic          rst_meta;
  logic          rst_n_int;
  logic [4:0]    raw;
  logic [4:0]    sync_p0;
  logic [4:0]    sync_p1;
  logic [4:0]    db_p2;
  logic [DW-1:0] db_cnt [5];
  rpt_state_t    rpt_state [4];
  logic [RW-1:0] rpt_cnt [4];

  assign raw = {BtnC, BtnR, BtnD, BtnU, BtnL};

  // Reset: asserts asynchronously, releases two clock edges after ResetN rises.
  always_ff @(posedge ClkPort or negedge ResetN) begin
    if (!ResetN) begin
      rst_meta  <= 1'b0;
      rst_n_int <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_n_int <= rst_meta;
    end
  end

  // Stage p0/p1: two-flop synchronizer on the raw buttons.
  always_ff @(posedge ClkPort or negedge rst_n_int) begin
    if (!rst_n_int) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: debounce; the level flips only after DB_CYCLES consecutive disagreements.
  always_ff @(posedge ClkPort or negedge rst_n_int) begin
    if (!rst_n_int) begin
      db_p2 <= '0;
      for (int i = 0; i < 5; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync_p1[i] != db_p2[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_p2[i]  <= sync_p1[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Stage p3: registered level and edge pulses.
  always_ff @(posedge ClkPort or negedge rst_n_int) begin
    if (!rst_n_int) begin
      Level   <= '0;
      Press   <= '0;
      Release <= '0;
    end else begin
      Level   <= db_p2;
      Press   <= db_p2 & ~Level;
      Release <= ~db_p2 & Level;
    end
  end

  // Stage p3: auto-repeat, aligned with Press so the first step lands on the press cycle.
  always_ff @(posedge ClkPort or negedge rst_n_int) begin
    if (!rst_n_int) begin
      Step <= '0;
      for (int i = 0; i < 4; i++) begin
        rpt_state[i] <= IDLE;
        rpt_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!db_p2[i]) begin
          rpt_state[i] <= IDLE;
          rpt_cnt[i]   <= '0;
          Step[i]      <= 1'b0;
        end else begin
          case (rpt_state[i])
            IDLE: begin
              rpt_cnt[i] <= '0;
              if (!Level[i]) begin
                rpt_state[i] <= DELAY;
                Step[i]      <= 1'b1;
              end else begin
                Step[i] <= 1'b0;
              end
            end
            DELAY: begin
              if (rpt_cnt[i] == RD_LAST) begin
                rpt_state[i] <= REPEAT;
                rpt_cnt[i]   <= '0;
                Step[i]      <= 1'b1;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                Step[i]    <= 1'b0;
              end
            end
            REPEAT: begin
              if (rpt_cnt[i] == RP_LAST) begin
                rpt_cnt[i] <= '0;
                Step[i]    <= 1'b1;
              end else begin
                rpt_cnt[i] <= rpt_cnt[i] + RW'(1);
                Step[i]    <= 1'b0;
              end
            end
            default: begin
              rpt_state[i] <= IDLE;
              rpt_cnt[i]   <= '0;
              Step[i]      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// checked every cycle against a sample-window reference model.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int HD = DB + 3;

  logic       clk = 1'b0;
  logic       ResetN = 1'b1;
  logic       BtnL = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
  logic [4:0] Level, Press, Release;
  logic [3:0] Step;

  button_conditioner #(
    .DB_CYCLES (DB),
    .RPT_DELAY (RD),
    .RPT_PERIOD(RP)
  ) dut (
    .ClkPort(clk),
    .ResetN (ResetN),
    .BtnL   (BtnL),
    .BtnU   (BtnU),
    .BtnD   (BtnD),
    .BtnR   (BtnR),
    .BtnC   (BtnC),
    .Level  (Level),
    .Press  (Press),
    .Release(Release),
    .Step   (Step)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model state
  int         cyc = 0;
  int         rcnt = 0;
  logic       hist [5][HD];
  logic [4:0] m_level = '0, m_press = '0, m_release = '0;
  logic [3:0] m_step = '0;
  int         age [4];
  int         press_q [5][$];
  int         rel_q [5][$];
  int         step_q [4][$];
  int         pulse_total = 0;
  int         lvl_hi = 0;

  // A debounced level flips once the DB raw samples taken 3..DB+2 edges ago all disagree with it.
  always @(posedge clk) begin
    logic [4:0] raw;
    logic       active;
    logic       flip;
    cyc++;
    raw = {BtnC, BtnR, BtnD, BtnU, BtnL};
    active = ResetN && (rcnt >= 2);
    if (!ResetN) rcnt = 0;
    else if (rcnt < 2) rcnt++;
    m_press = '0;
    m_release = '0;
    m_step = '0;
    if (!active) begin
      m_level = '0;
      for (int b = 0; b < 5; b++)
        for (int k = 0; k < HD; k++) hist[b][k] = 1'b0;
    end else begin
      for (int b = 0; b < 5; b++) begin
        for (int k = HD - 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = raw[b];
        flip = 1'b1;
        for (int k = 3; k < HD; k++)
          if (hist[b][k] == m_level[b]) flip = 1'b0;
        if (flip) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) m_press[b] = 1'b1;
          else m_release[b] = 1'b1;
        end
      end
      for (int d = 0; d < 4; d++) begin
        if (m_press[d]) age[d] = 0;
        else if (m_level[d]) age[d]++;
        m_step[d] = m_level[d] && (age[d] == 0 || (age[d] >= RD && (age[d] - RD) % RP == 0));
      end
    end
    for (int b = 0; b < 5; b++) begin
      if (m_press[b]) press_q[b].push_back(cyc);
      if (m_release[b]) rel_q[b].push_back(cyc);
    end
    for (int d = 0; d < 4; d++)
      if (m_step[d]) step_q[d].push_back(cyc);
    pulse_total += $countones(m_press) + $countones(m_release) + $countones(m_step);
    lvl_hi += $countones(m_level);
    #1;
    chk("Level", int'(Level), int'(m_level));
    chk("Press", int'(Press), int'(m_press));
    chk("Release", int'(Release), int'(m_release));
    chk("Step", int'(Step), int'(m_step));
  end

  task automatic clear_log();
    for (int b = 0; b < 5; b++) begin
      press_q[b].delete();
      rel_q[b].delete();
    end
    for (int d = 0; d < 4; d++) step_q[d].delete();
    pulse_total = 0;
    lvl_hi = 0;
  endtask

  task automatic check_q(input string name, input int got[$], input int n,
                         input int a0, input int a1, input int a2, input int a3);
    int ex[4];
    ex[0] = a0; ex[1] = a1; ex[2] = a2; ex[3] = a3;
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      chk($sformatf("%s[%0d]", name, i), got[i], ex[i]);
  endtask

  task automatic wait_until(input int edge_n);
    while (cyc < edge_n) @(negedge clk);
  endtask

  initial begin
    int e0, f, k, t;
    int hold [5];
    logic [4:0] btn;
    #2 ResetN = 1'b0;
    #1;
    chk("reset_level", int'(Level), 0);
    chk("reset_press", int'(Press), 0);
    chk("reset_release", int'(Release), 0);
    chk("reset_step", int'(Step), 0);
    repeat (3) @(negedge clk);
    ResetN = 1'b1;
    repeat (6) @(negedge clk);

    // BtnU held: press at +6, steps at +6, +16, +19, +22
    clear_log();
    BtnU = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 24);
    check_q("u_press", press_q[1], 1, e0 + 6, 0, 0, 0);
    check_q("u_step", step_q[1], 4, e0 + 6, e0 + 16, e0 + 19, e0 + 22);
    chk("u_pulses", pulse_total, 5);
    BtnU = 1'b0;
    f = cyc + 1;
    wait_until(f + 8);
    check_q("u_release", rel_q[1], 1, f + 6, 0, 0, 0);

    // BtnL glitch of 3 samples
    clear_log();
    BtnL = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 2);
    BtnL = 1'b0;
    wait_until(e0 + 20);
    chk("glitch_pulses", pulse_total, 0);
    chk("glitch_level", lvl_hi, 0);

    // BtnR high for 12 samples
    clear_log();
    BtnR = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 11);
    BtnR = 1'b0;
    wait_until(e0 + 24);
    check_q("r_press", press_q[3], 1, e0 + 6, 0, 0, 0);
    check_q("r_step", step_q[3], 2, e0 + 6, e0 + 16, 0, 0);
    check_q("r_release", rel_q[3], 1, e0 + 18, 0, 0, 0);

    // BtnL and BtnD together
    clear_log();
    BtnL = 1'b1;
    BtnD = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 20);
    check_q("ld_press_l", press_q[0], 1, e0 + 6, 0, 0, 0);
    check_q("ld_press_d", press_q[2], 1, e0 + 6, 0, 0, 0);
    check_q("ld_step_l", step_q[0], 3, e0 + 6, e0 + 16, e0 + 19, 0);
    check_q("ld_step_d", step_q[2], 3, e0 + 6, e0 + 16, e0 + 19, 0);
    BtnL = 1'b0;
    BtnD = 1'b0;
    wait_until(cyc + 10);

    // BtnC held through a reset pulse
    clear_log();
    BtnC = 1'b1;
    e0 = cyc + 1;
    wait_until(e0 + 11);
    ResetN = 1'b0;
    #1;
    chk("async_level", int'(Level), 0);
    chk("async_press", int'(Press), 0);
    chk("async_release", int'(Release), 0);
    chk("async_step", int'(Step), 0);
    repeat (2) @(negedge clk);
    ResetN = 1'b1;
    k = cyc + 1;
    wait_until(k + 12);
    check_q("c_press", press_q[4], 2, e0 + 6, k + 8, 0, 0);
    chk("c_pulses", pulse_total, 2);
    BtnC = 1'b0;
    wait_until(cyc + 10);

    // BtnD chatter then held
    clear_log();
    for (int i = 0; i < 40; i++) begin
      BtnD = ((i / 2) % 2 == 0);
      @(negedge clk);
    end
    BtnD = 1'b1;
    t = cyc + 1;
    wait_until(t + 10);
    check_q("chatter_press", press_q[2], 1, t + 6, 0, 0, 0);
    chk("chatter_pulses", pulse_total, 2);
    BtnD = 1'b0;
    wait_until(cyc + 10);

    // Random activity with occasional resets
    for (int b = 0; b < 5; b++) hold[b] = 0;
    btn = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold[b] == 0) begin
          btn[b] = ~btn[b];
          hold[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6);
        end else begin
          hold[b]--;
        end
      end
      {BtnC, BtnR, BtnD, BtnU, BtnL} = btn;
      if (ResetN && $urandom_range(0, 399) == 0) ResetN = 1'b0;
      else if (!ResetN && $urandom_range(0, 1) == 0) ResetN = 1'b1;
      @(negedge clk);
    end
    ResetN = 1'b1;
    {BtnC, BtnR, BtnD, BtnU, BtnL} = '0;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
